// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the memory-stage LSU: req/gnt/rvalid handshake.
// The LSU is the master; the data memory (or its model) is the slave.
interface mem_stage_lsu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [3:0]       be;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues byte/half/word accesses on a variable-latency
// req/gnt/rvalid port, stalls the pipeline while outstanding, returns extended load data.
module mem_stage_lsu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memreadM,
    input  logic             memwriteM,
    input  logic [2:0]       memctrlM,
    input  logic [WIDTH-1:0] aluresultM,
    input  logic [WIDTH-1:0] writedataM,
    output logic             stallM,
    output logic [WIDTH-1:0] loaddataM,
    output logic             loadvalidM,
    output logic             misalignM,
    mem_stage_lsu_if.master  dmem
);

    typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRsp, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_addr;
    logic [2:0]       r_ctrl;
    logic             r_we;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_loaddata;
    logic             r_loadvalid;

    logic w_acc;
    logic w_store;
    logic w_mis;
    logic w_start;

    function automatic logic [3:0] f_be(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl[1:0])
            2'b00:   f_be = 4'b0001 << off;
            2'b01:   f_be = 4'b0011 << off;
            default: f_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] f_wdata(input logic [2:0] ctrl,
                                                 input logic [WIDTH-1:0] wd);
        case (ctrl[1:0])
            2'b00:   f_wdata = {4{wd[7:0]}};
            2'b01:   f_wdata = {2{wd[15:0]}};
            default: f_wdata = wd;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] f_extend(input logic [2:0] ctrl, input logic [1:0] off,
                                                  input logic [WIDTH-1:0] rdata);
        logic [WIDTH-1:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (ctrl)
            3'b000:  f_extend = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  f_extend = {24'h0, shifted[7:0]};
            3'b001:  f_extend = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  f_extend = {16'h0, shifted[15:0]};
            default: f_extend = rdata;
        endcase
    endfunction

    // Read wins when both are asserted, so only a pure write counts as a store.
    assign w_acc   = memreadM | memwriteM;
    assign w_store = memwriteM & ~memreadM;
    assign w_mis   = (memctrlM == 3'b011) || (memctrlM[2:1] == 2'b11)
                   || ((memctrlM[1:0] == 2'b01) && aluresultM[0])
                   || ((memctrlM == 3'b010) && (aluresultM[1:0] != 2'b00))
                   || (w_store && memctrlM[2]);
    assign w_start = w_acc & ~w_mis;

    assign loaddataM  = r_loaddata;
    assign loadvalidM = r_loadvalid;

    always_comb begin
        dmem.req   = 1'b0;
        dmem.we    = 1'b0;
        dmem.addr  = '0;
        dmem.wdata = '0;
        dmem.be    = 4'b0000;
        stallM     = 1'b0;
        misalignM  = 1'b0;
        unique case (r_state)
            StIdle: begin
                misalignM = w_acc & w_mis;
                if (w_start) begin
                    dmem.req   = 1'b1;
                    dmem.we    = w_store;
                    dmem.addr  = {aluresultM[WIDTH-1:2], 2'b00};
                    dmem.wdata = f_wdata(memctrlM, writedataM);
                    dmem.be    = f_be(memctrlM, aluresultM[1:0]);
                    stallM     = w_store ? ~dmem.gnt : 1'b1;
                end
            end
            StWaitGnt: begin
                dmem.req   = 1'b1;
                dmem.we    = r_we;
                dmem.addr  = {r_addr[WIDTH-1:2], 2'b00};
                dmem.wdata = f_wdata(r_ctrl, r_wdata);
                dmem.be    = f_be(r_ctrl, r_addr[1:0]);
                stallM     = r_we ? ~dmem.gnt : 1'b1;
            end
            StWaitRsp: stallM = 1'b1;
            default:   ;
        endcase
        // The state is already IDLE during reset, but the inputs may still request.
        if (rst) begin
            dmem.req  = 1'b0;
            stallM    = 1'b0;
            misalignM = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_ctrl      <= 3'b000;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_loaddata  <= '0;
            r_loadvalid <= 1'b0;
        end else begin
            r_loadvalid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_addr  <= aluresultM;
                        r_ctrl  <= memctrlM;
                        r_we    <= w_store;
                        r_wdata <= writedataM;
                        if (!dmem.gnt) begin
                            r_state <= StWaitGnt;
                        end else if (!w_store) begin
                            r_state <= StWaitRsp;
                        end
                    end
                end
                StWaitGnt: begin
                    if (dmem.gnt) begin
                        r_state <= r_we ? StIdle : StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (dmem.rvalid) begin
                        r_loaddata  <= f_extend(r_ctrl, r_addr[1:0], dmem.rdata);
                        r_loadvalid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu: drives the pipeline inputs and a scripted
// memory responder, checking handshake, stall counts and extended load data.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memreadM = 1'b0;
    logic        memwriteM = 1'b0;
    logic [2:0]  memctrlM = 3'b000;
    logic [31:0] aluresultM = '0;
    logic [31:0] writedataM = '0;
    logic        stallM;
    logic [31:0] loaddataM;
    logic        loadvalidM;
    logic        misalignM;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_lsu_if #(.WIDTH(32)) dmem_if ();

    mem_stage_lsu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .memctrlM   (memctrlM),
        .aluresultM (aluresultM),
        .writedataM (writedataM),
        .stallM     (stallM),
        .loaddataM  (loaddataM),
        .loadvalidM (loadvalidM),
        .misalignM  (misalignM),
        .dmem       (dmem_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one M-stage instruction; gnt arrives gnt_dly cycles after issue, rvalid one after gnt.
    task automatic run_acc(input string tag, input logic rd, input logic wr,
                           input logic [2:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wd, input int gnt_dly, input logic [31:0] rdata,
                           input int exp_stall, input int exp_req, input logic exp_mis,
                           input logic exp_we, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic exp_lv, input logic [31:0] exp_ld);
        int  n_st = 0;
        int  n_rq = 0;
        bit  done = 0;
        memreadM   = rd;
        memwriteM  = wr;
        memctrlM   = ctrl;
        aluresultM = addr;
        writedataM = wd;
        for (int k = 0; k < 20 && !done; k++) begin
            // Upstream holds, but scramble address/data after issue to prove they are latched.
            if (k > 0) begin
                aluresultM = 32'hFFFF_FFFF;
                writedataM = 32'h0;
            end
            dmem_if.gnt    = (k == gnt_dly);
            dmem_if.rvalid = rd && (k == gnt_dly + 1);
            dmem_if.rdata  = rdata;
            @(negedge clk);
            if (k == 0) chk({tag, "_mis"}, {31'b0, misalignM}, {31'b0, exp_mis});
            if (dmem_if.req) begin
                chk({tag, "_we"}, {31'b0, dmem_if.we}, {31'b0, exp_we});
                chk({tag, "_addr"}, dmem_if.addr, exp_addr);
                chk({tag, "_be"}, {28'b0, dmem_if.be}, {28'b0, exp_be});
                if (exp_we) chk({tag, "_wdata"}, dmem_if.wdata, exp_wdata);
            end
            n_st += int'(stallM);
            n_rq += int'(dmem_if.req);
            if (!stallM) begin
                done = 1;
                chk({tag, "_lv"}, {31'b0, loadvalidM}, {31'b0, exp_lv});
                if (exp_lv) chk({tag, "_ld"}, loaddataM, exp_ld);
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_nstall"}, n_st, exp_stall);
        chk({tag, "_nreq"}, n_rq, exp_req);
        memreadM       = 1'b0;
        memwriteM      = 1'b0;
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b0;
    endtask

    initial begin
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = '0;
        @(negedge clk);
        chk("rst_stall", {31'b0, stallM}, 32'd0);
        chk("rst_req", {31'b0, dmem_if.req}, 32'd0);
        chk("rst_ld", loaddataM, 32'd0);
        chk("rst_lv", {31'b0, loadvalidM}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // tag rd wr ctrl addr wd gnt_dly rdata | stall req mis we addr be wdata lv ld
        run_acc("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0,
                0, 1, 0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        chk("sw_idle_req", {31'b0, dmem_if.req}, 32'd0);
        chk("sw_idle_stall", {31'b0, stallM}, 32'd0);
        @(posedge clk);
        #1;
        run_acc("sb", 0, 1, 3'b000, 32'h103, 32'h000000A5, 2, 0,
                2, 3, 0, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 0, 0);
        run_acc("sh", 0, 1, 3'b001, 32'h102, 32'h0000BEEF, 0, 0,
                0, 1, 0, 1, 32'h100, 4'b1100, 32'hBEEFBEEF, 0, 0);
        run_acc("lb", 1, 0, 3'b000, 32'h102, 0, 0, 32'h12F08034,
                2, 1, 0, 0, 32'h100, 4'b0100, 0, 1, 32'hFFFFFFF0);
        run_acc("lhu", 1, 0, 3'b101, 32'h102, 0, 0, 32'h12F08034,
                2, 1, 0, 0, 32'h100, 4'b1100, 0, 1, 32'h000012F0);
        run_acc("lh", 1, 0, 3'b001, 32'h102, 0, 0, 32'h12F08034,
                2, 1, 0, 0, 32'h100, 4'b1100, 0, 1, 32'h000012F0);
        run_acc("lbu", 1, 0, 3'b100, 32'h101, 0, 1, 32'h12F08034,
                3, 2, 0, 0, 32'h100, 4'b0010, 0, 1, 32'h00000080);
        run_acc("lw_mis", 1, 0, 3'b010, 32'h102, 0, 0, 0,
                0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_acc("hu_store", 0, 1, 3'b101, 32'h100, 0, 0, 0,
                0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_acc("bad_ctrl", 1, 0, 3'b011, 32'h100, 0, 0, 0,
                0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_acc("lw_b2b", 1, 0, 3'b010, 32'h200, 0, 0, 32'hCAFEF00D,
                2, 1, 0, 0, 32'h200, 4'b1111, 0, 1, 32'hCAFEF00D);
        run_acc("sw_b2b", 0, 1, 3'b010, 32'h204, 32'h11223344, 0, 0,
                0, 1, 0, 1, 32'h204, 4'b1111, 32'h11223344, 0, 0);
        run_acc("rdwr", 1, 1, 3'b010, 32'h300, 32'h99999999, 0, 32'h55AA55AA,
                2, 1, 0, 0, 32'h300, 4'b1111, 0, 1, 32'h55AA55AA);

        // Reset while a load waits for its response.
        memreadM   = 1'b1;
        memctrlM   = 3'b010;
        aluresultM = 32'h400;
        dmem_if.gnt = 1'b1;
        @(posedge clk);
        #1 dmem_if.gnt = 1'b0;
        @(negedge clk);
        chk("wrsp_stall", {31'b0, stallM}, 32'd1);
        chk("pre_rst_ld", loaddataM, 32'h55AA55AA);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_stall", {31'b0, stallM}, 32'd0);
        chk("mid_rst_req", {31'b0, dmem_if.req}, 32'd0);
        chk("mid_rst_ld", loaddataM, 32'd0);
        memreadM = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        dmem_if.rvalid = 1'b1;
        dmem_if.rdata  = 32'h12345678;
        @(posedge clk);
        #1 dmem_if.rvalid = 1'b0;
        @(negedge clk);
        chk("late_rv_ld", loaddataM, 32'd0);
        chk("late_rv_lv", {31'b0, loadvalidM}, 32'd0);
        chk("late_rv_stall", {31'b0, stallM}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
